// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
package ex_div_unit_pkg;

    // Operand width of the divider; the result bus is twice this wide.
    localparam int DIV_WIDTH = 32;

    // FSM encodings shared with the rest of the EX stage.
    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_BUSY   = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

endpackage : ex_div_unit_pkg

// File: rtl/ex_div_unit_step.sv
// One radix-2 restoring-division iteration: shift in the next dividend bit,
// compare against the divisor, and subtract when it fits.
module ex_div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    // Shifted partial remainder is one bit wider so the compare never overflows.
    logic [WIDTH:0] shifted_s;

    // Shift-compare-subtract; the difference is always below the divisor, so it fits in WIDTH bits.
    always_comb begin
        shifted_s = {rem_i, dvd_msb_i};
        rem_o     = shifted_s[WIDTH-1:0];
        qbit_o    = 1'b0;
        if (shifted_s >= {1'b0, dvs_i}) begin
            rem_o  = shifted_s[WIDTH-1:0] - dvs_i;
            qbit_o = 1'b1;
        end else begin
            rem_o  = shifted_s[WIDTH-1:0];
            qbit_o = 1'b0;
        end
    end

endmodule : ex_div_unit_step

// File: rtl/ex_div_unit.sv
// EX-stage DIV/DIVU unit: 32-iteration radix-2 divider that stalls the front
// of the pipeline while running and pulses ready with {HI, LO} when done.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0]   quo_q, quo_d;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH-1:0]   step_rem_s;
    logic               step_qbit_s;
    logic [WIDTH-1:0]   final_quo_s, final_rem_s;
    logic [WIDTH-1:0]   fixed_quo_s, fixed_rem_s;

    ex_div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (quo_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem_s),
        .qbit_o    (step_qbit_s)
    );

    // Operand magnitudes and the sign fix-up applied on the final iteration.
    always_comb begin
        mag_a_s     = opdata1_i;
        mag_b_s     = opdata2_i;
        final_quo_s = {quo_q[WIDTH-2:0], step_qbit_s};
        final_rem_s = step_rem_s;
        fixed_quo_s = final_quo_s;
        fixed_rem_s = final_rem_s;
        if (signed_div_i && opdata1_i[WIDTH-1]) begin
            mag_a_s = ~opdata1_i + ONE_W;
        end else begin
            mag_a_s = opdata1_i;
        end
        if (signed_div_i && opdata2_i[WIDTH-1]) begin
            mag_b_s = ~opdata2_i + ONE_W;
        end else begin
            mag_b_s = opdata2_i;
        end
        if (neg_quo_q) begin
            fixed_quo_s = ~final_quo_s + ONE_W;
        end else begin
            fixed_quo_s = final_quo_s;
        end
        if (neg_rem_q) begin
            fixed_rem_s = ~final_rem_s + ONE_W;
        end else begin
            fixed_rem_s = final_rem_s;
        end
    end

    // Next-state logic: operand capture, iteration, completion and annul handling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == ZERO_W) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_BUSY;
                        dvs_d     = mag_b_s;
                        quo_d     = mag_a_s;
                        rem_d     = ZERO_W;
                        cnt_d     = {CNT_W{1'b0}};
                        neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d  = DIV_DONE;
                    result_d = {2*WIDTH{1'b0}};
                    ready_d  = 1'b1;
                end
            end
            DIV_BUSY: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = final_quo_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DIV_DONE;
                        result_d = {fixed_rem_s, fixed_quo_s};
                        ready_d  = 1'b1;
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            dvs_q     <= ZERO_W;
            quo_q     <= ZERO_W;
            rem_q     <= ZERO_W;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {2*WIDTH{1'b0}};
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule : ex_div_unit

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int n_vec = 0;
    int n_err = 0;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start with operands (cycle 0) and follow until ready; leaves start high.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int rdy_cyc, output int stalls);
        rdy_cyc = -1;
        stalls  = 0;
        res     = 64'h0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stallreq) stalls++;
            if (ready) begin
                rdy_cyc = c;
                res     = result;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drop_start;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; opdata1 = 32'h0; opdata2 = 32'h0; annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (result !== 64'h0 || ready !== 1'b0 || stallreq !== 1'b0) begin
            n_err++;
            $display("FAIL reset: result=%h ready=%b stallreq=%b, want 0/0/0", result, ready, stallreq);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_divu_basic;
        logic [63:0] res; int rc; int st;
        run_div(1'b0, 32'd100, 32'd7, res, rc, st);
        n_vec++;
        if (res !== {32'd2, 32'd14}) begin
            n_err++; $display("FAIL divu_100_7: result=%h want %h", res, {32'd2, 32'd14});
        end
        n_vec++;
        if (rc !== 33) begin
            n_err++; $display("FAIL divu_latency: ready at cycle %0d want 33", rc);
        end
        n_vec++;
        if (st !== 33) begin
            n_err++; $display("FAIL divu_stall: stallreq high %0d cycles want 33", st);
        end
        drop_start();
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL ready_pulse: ready=%b one cycle later, want 0", ready);
        end
    endtask

    task automatic test_signed;
        logic [63:0] res; int rc; int st;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, rc, st);
        drop_start();
        n_vec++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_err++; $display("FAIL div_m7_2: result=%h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        end
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, rc, st);
        drop_start();
        n_vec++;
        if (res !== {32'd1, 32'hFFFF_FFFD}) begin
            n_err++; $display("FAIL div_7_m2: result=%h want %h", res, {32'd1, 32'hFFFF_FFFD});
        end
    endtask

    task automatic test_div_by_zero;
        logic [63:0] res; int rc; int st;
        run_div(1'b1, 32'h1234_5678, 32'h0, res, rc, st);
        drop_start();
        n_vec++;
        if (res !== 64'h0) begin
            n_err++; $display("FAIL divzero_result: result=%h want 0", res);
        end
        n_vec++;
        if (rc !== 2) begin
            n_err++; $display("FAIL divzero_latency: ready at cycle %0d want 2", rc);
        end
        n_vec++;
        if (st !== 2) begin
            n_err++; $display("FAIL divzero_stall: stallreq high %0d cycles want 2", st);
        end
    endtask

    task automatic test_overflow_case;
        logic [63:0] res; int rc; int st;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, rc, st);
        drop_start();
        n_vec++;
        if (res !== {32'h0, 32'h8000_0000}) begin
            n_err++; $display("FAIL div_min_m1: result=%h want %h", res, {32'h0, 32'h8000_0000});
        end
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, rc, st);
        drop_start();
        n_vec++;
        if (res !== {32'h8000_0000, 32'h0}) begin
            n_err++; $display("FAIL divu_min_max: result=%h want %h", res, {32'h8000_0000, 32'h0});
        end
    endtask

    task automatic test_annul;
        logic [63:0] prior; int seen;
        prior = result;
        seen  = 0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(negedge clk);
        n_vec++;
        if (stallreq !== 1'b0) begin
            n_err++; $display("FAIL annul_stall: stallreq=%b want 0", stallreq);
        end
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL annul_ready: %0d ready pulses after annul, want 0", seen);
        end
        n_vec++;
        if (result !== prior) begin
            n_err++; $display("FAIL annul_result: result=%h want %h", result, prior);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res; int rc; int st;
        run_div(1'b0, 32'd50, 32'd5, res, rc, st);
        n_vec++;
        if (res !== {32'd0, 32'd10}) begin
            n_err++; $display("FAIL b2b_first: result=%h want %h", res, {32'd0, 32'd10});
        end
        run_div(1'b0, 32'd9, 32'd4, res, rc, st);
        drop_start();
        n_vec++;
        if (res !== {32'd1, 32'd2}) begin
            n_err++; $display("FAIL b2b_second: result=%h want %h", res, {32'd1, 32'd2});
        end
        n_vec++;
        if (rc !== 33) begin
            n_err++; $display("FAIL b2b_latency: ready at cycle %0d want 33", rc);
        end
    endtask

    task automatic test_midop_reset;
        int seen;
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd3;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (result !== 64'h0 || ready !== 1'b0 || stallreq !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset: result=%h ready=%b stallreq=%b, want 0/0/0", result, ready, stallreq);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL midop_reset_ready: %0d ready pulses after reset, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_by_zero();
        test_overflow_case();
        test_annul();
        test_back_to_back();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ex_div_unit
